// File: rtl/fpu_request_arbiter_if.sv
// Requester-side bundle of the FPU arbiter: two request ports plus the shared response bus.
// The arbiter takes the slave modport, requesters take master.
interface fpu_request_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             resp_timeout;
    logic             busy;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  req_ready, resp_valid, resp_data, resp_timeout, busy
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output req_ready, resp_valid, resp_data, resp_timeout, busy
    );
endinterface

// File: rtl/fpu_request_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of one shared Fixed_Point_Unit.
// One operation in flight; operands held until fpu_ready, watchdog retires stuck ops.
module fpu_request_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    fpu_request_arbiter_if.slave rq,
    output logic [WIDTH-1:0]    fpu_operand_1,
    output logic [WIDTH-1:0]    fpu_operand_2,
    output logic [1:0]          fpu_operation,
    input  logic [WIDTH-1:0]    fpu_result,
    input  logic                fpu_ready
);
    localparam logic [1:0] FPU_ADD = 2'b00;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt_q;
    logic             gnt_sel;
    logic             accept;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_timeout_q;

    logic [1:0][1:0]       port_op;
    logic [1:0][WIDTH-1:0] port_a;
    logic [1:0][WIDTH-1:0] port_b;

    assign port_op = {rq.req_op1, rq.req_op0};
    assign port_a  = {rq.req_a1, rq.req_a0};
    assign port_b  = {rq.req_b1, rq.req_b0};

    // Under contention the port that did not win last time goes next.
    always_comb begin
        if (&rq.req_valid) gnt_sel = ~last_grant;
        else               gnt_sel = rq.req_valid[1];
    end

    assign accept       = (state == IDLE) && (|rq.req_valid);
    assign rq.req_ready = accept ? (2'b01 << gnt_sel) : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            gnt_q          <= 1'b0;
            op_q           <= FPU_ADD;
            a_q            <= '0;
            b_q            <= '0;
            cnt            <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_q      <= gnt_sel;
                        last_grant <= gnt_sel;
                        op_q       <= port_op[gnt_sel];
                        a_q        <= port_a[gnt_sel];
                        b_q        <= port_b[gnt_sel];
                        state      <= ISSUE;
                    end
                end
                // fpu_ready may still be stale from the previous op here, so it is not looked at.
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fpu_ready) begin
                        resp_data_q    <= fpu_result;
                        resp_timeout_q <= 1'b0;
                        state          <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_data_q    <= '0;
                        resp_timeout_q <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // In IDLE the FPU sees a harmless 0 + 0 instead of the last operation.
    assign fpu_operation   = (state == IDLE) ? FPU_ADD : op_q;
    assign fpu_operand_1   = (state == IDLE) ? '0 : a_q;
    assign fpu_operand_2   = (state == IDLE) ? '0 : b_q;

    assign rq.resp_valid   = (state == RESP) ? (2'b01 << gnt_q) : 2'b00;
    assign rq.resp_data    = resp_data_q;
    assign rq.resp_timeout = resp_timeout_q;
    assign rq.busy         = (state != IDLE);
endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Directed bench for fpu_request_arbiter: vector table of single ops plus contention and reset sequences.
module tb_fpu_request_arbiter;
    localparam int W = 32;
    localparam int T = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] fop1, fop2, fres;
    logic [1:0]   fop;
    logic         frdy;

    fpu_request_arbiter_if #(.WIDTH(W)) bus();

    fpu_request_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .rq            (bus),
        .fpu_operand_1 (fop1),
        .fpu_operand_2 (fop2),
        .fpu_operation (fop),
        .fpu_result    (fres),
        .fpu_ready     (frdy)
    );

    always #5 clk = ~clk;

    // FPU model: Q-format with 10 fraction bits; ready timed from the accept edge.
    int   since    = 0;
    int   ready_at = 1000;
    logic stale    = 1'b0;

    always @(posedge clk) since <= (|bus.req_ready) ? 1 : ((since < 100000) ? since + 1 : since);

    always_comb begin
        case (fop)
            2'd0:    fres = fop1 + fop2;
            2'd1:    fres = fop1 - fop2;
            2'd2:    fres = W'((64'(fop1) * 64'(fop2)) >> 10);
            default: fres = '0;
        endcase
    end
    assign frdy = (since >= ready_at) || (stale && since == 1);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"},  64'(bus.req_ready), 64'd0);
        chk({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, " resp_data"},  64'(bus.resp_data), 64'd0);
        chk({tag, " resp_to"},    64'(bus.resp_timeout), 64'd0);
        chk({tag, " busy"},       64'(bus.busy), 64'd0);
        chk({tag, " fpu_op"},     64'(fop), 64'd0);
        chk({tag, " fpu_a"},      64'(fop1), 64'd0);
        chk({tag, " fpu_b"},      64'(fop2), 64'd0);
    endtask

    typedef struct {
        bit          port;
        logic [1:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int          rdy_at;
        bit          stale;
        logic [W-1:0] exp_data;
        bit          exp_to;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] oh;
        int         rc;
        oh       = 2'b01 << v.port;
        rc       = -1;
        ready_at = v.rdy_at;
        stale    = v.stale;
        if (v.port) begin bus.req_op1 = v.op; bus.req_a1 = v.a; bus.req_b1 = v.b; end
        else        begin bus.req_op0 = v.op; bus.req_a0 = v.a; bus.req_b0 = v.b; end
        bus.req_valid = oh;
        @(negedge clk);
        chk($sformatf("v%0d accept", idx), 64'(bus.req_ready), 64'(oh));
        chk($sformatf("v%0d idle_busy", idx), 64'(bus.busy), 64'd0);
        step();
        bus.req_valid = 2'b00;
        for (int c = 1; c <= T + 10 && rc < 0; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d busy c%0d", idx, c), 64'(bus.busy), 64'd1);
            chk($sformatf("v%0d fpu_op c%0d", idx, c), 64'(fop), 64'(v.op));
            chk($sformatf("v%0d fpu_a c%0d", idx, c), 64'(fop1), 64'(v.a));
            chk($sformatf("v%0d fpu_b c%0d", idx, c), 64'(fop2), 64'(v.b));
            chk($sformatf("v%0d no_ready c%0d", idx, c), 64'(bus.req_ready), 64'd0);
            if (bus.resp_valid != 2'b00) begin
                rc = c;
                chk($sformatf("v%0d resp_valid", idx), 64'(bus.resp_valid), 64'(oh));
                chk($sformatf("v%0d resp_data", idx), 64'(bus.resp_data), 64'(v.exp_data));
                chk($sformatf("v%0d resp_to", idx), 64'(bus.resp_timeout), 64'(v.exp_to));
            end
            step();
        end
        chk($sformatf("v%0d resp_cycle", idx), 64'(rc), 64'(v.exp_cyc));
        stale    = 1'b0;
        ready_at = 1000;
    endtask

    logic [1:0] exp_rdy[12];
    logic [1:0] exp_rv[12];

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0000_0C00, 32'h0000_0400, 1,    1'b0, 32'h0000_1000, 1'b0, 3};
        vecs[1] = '{1'b1, 2'd2, 32'h0000_0800, 32'h0000_0800, 5,    1'b0, 32'h0000_1000, 1'b0, 6};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0010, 32'h0000_0030, 1,    1'b0, 32'hFFFF_FFE0, 1'b0, 3};
        vecs[3] = '{1'b1, 2'd0, 32'h0000_1111, 32'h0000_2222, 1000, 1'b0, 32'h0000_0000, 1'b1, 66};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_0007, 32'h0000_0008, 1,    1'b0, 32'h0000_000F, 1'b0, 3};
        vecs[5] = '{1'b0, 2'd2, 32'h0000_0C00, 32'h0000_0400, 5,    1'b1, 32'h0000_0C00, 1'b0, 6};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_0002, 32'h0000_0003, 65,   1'b0, 32'h0000_0005, 1'b0, 66};
        vecs[7] = '{1'b0, 2'd1, 32'h0000_0009, 32'h0000_0004, 64,   1'b0, 32'h0000_0005, 1'b0, 65};

        for (int i = 0; i < 12; i++) begin exp_rdy[i] = 2'b00; exp_rv[i] = 2'b00; end
        exp_rdy[0] = 2'b01; exp_rdy[4] = 2'b10; exp_rdy[8]  = 2'b01;
        exp_rv[3]  = 2'b01; exp_rv[7]  = 2'b10; exp_rv[11] = 2'b01;

        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op0 = 2'd0; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1 = 2'd0; bus.req_a1 = '0; bus.req_b1 = '0;
        @(negedge clk);
        chk_reset_vals("reset");
        step();
        reset = 1'b0;

        // Contention: both ports held valid; grants alternate 0,1,0.
        ready_at = 1;
        bus.req_op0 = 2'd1; bus.req_a0 = 32'd5; bus.req_b0 = 32'd3;
        bus.req_op1 = 2'd0; bus.req_a1 = 32'd1; bus.req_b1 = 32'd1;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("cont req_ready c%0d", c), 64'(bus.req_ready), 64'(exp_rdy[c]));
            chk($sformatf("cont resp_valid c%0d", c), 64'(bus.resp_valid), 64'(exp_rv[c]));
            if (exp_rv[c] != 2'b00)
                chk($sformatf("cont resp_data c%0d", c), 64'(bus.resp_data), 64'd2);
            step();
            if (c == 8) bus.req_valid = 2'b00;
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during WAIT: outputs clear at once, no response, arbitration restarts at port 0.
        ready_at = 1000;
        bus.req_op0 = 2'd0; bus.req_a0 = 32'h55; bus.req_b0 = 32'h66;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("rst_mid accept", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        repeat (6) step();
        chk("rst_mid busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid quiet c%0d", c), 64'({bus.resp_valid, bus.busy}), 64'd0);
            step();
        end
        ready_at = 1;
        bus.req_op0 = 2'd0; bus.req_a0 = 32'd1; bus.req_b0 = 32'd2;
        bus.req_op1 = 2'd0; bus.req_a1 = 32'd7; bus.req_b1 = 32'd7;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst grant", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        repeat (2) step();
        @(negedge clk);
        chk("post_rst resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("post_rst resp_data", 64'(bus.resp_data), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "time limit");
    end
endmodule
